// File: rtl/alu_op_decoder.sv
// alu_op_decoder: decodes RV32I OP (and OP-IMM when ALU_DEC_IMM_EN is
// defined) into ALU operands and ALUType behind a 2-entry skid buffer.
// Ports: clk, rst (async, active-high); in_valid/in_ready + instr,
// rs1_data, rs2_data; out_valid/out_ready + src1, src2, ALUType, rd,
// illegal; illegal_cnt (saturating count of accepted illegal words).
module alu_op_decoder #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [OP_W-1:0]   ALUType,
  output logic [4:0]        rd,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_OR   = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_AND  = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_NDEF = OP_W'(8);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [OP_W-1:0]   op;
    logic [4:0]        rd;
    logic              ill;
  } pay_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_n;
  pay_t   dec, out_q, skid_q;
  logic   push, pop;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_op;
  logic       is_imm;
  logic       unused_bits;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign is_op  = (opc == OPC_OP);
  assign is_imm = (opc == OPC_IMM);
  assign unused_bits = ^{instr[24:15], is_imm};

  always_comb begin
    dec      = '0;
    dec.src1 = rs1_data;
    dec.src2 = rs2_data;
    dec.rd   = instr[11:7];
    dec.op   = ALU_NDEF;
    dec.ill  = 1'b1;
    unique case (1'b1)
      (is_op && f7 == 7'h00): begin
        dec.ill = 1'b0;
        unique case (f3)
          3'b000: dec.op = ALU_ADD;
          3'b001: dec.op = ALU_SLL;
          3'b010: dec.op = ALU_SLT;
          3'b100: dec.op = ALU_XOR;
          3'b101: dec.op = ALU_SRL;
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
          3'b011: dec.ill = 1'b1;
        endcase
      end
      (is_op && f7 == 7'h20 && f3 == 3'b000): begin
        dec.op  = ALU_SUB;
        dec.ill = 1'b0;
      end
`ifdef ALU_DEC_IMM_EN
      is_imm: begin
        dec.src2 = {{(DATA_W-12){instr[31]}}, instr[31:20]};
        dec.ill  = 1'b0;
        unique case (f3)
          3'b000: dec.op = ALU_ADD;
          3'b010: dec.op = ALU_SLT;
          3'b100: dec.op = ALU_XOR;
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
          3'b001: begin
            if (f7 == 7'h00) dec.op = ALU_SLL;
            else dec.ill = 1'b1;
          end
          3'b101: begin
            if (f7 == 7'h00) dec.op = ALU_SRL;
            else dec.ill = 1'b1;
          end
          3'b011: dec.ill = 1'b1;
        endcase
      end
`endif
      default: ;
    endcase
    if (dec.ill) dec.op = ALU_NDEF;
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (push) state_n = HOLD;
      HOLD: begin
        if (push && !pop) state_n = FULL;
        else if (pop && !push) state_n = EMPTY;
      end
      FULL: if (pop) state_n = HOLD;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      illegal_cnt <= '0;
    end else begin
      state     <= state_n;
      // both handshakes come straight from the next state, so
      // in_ready never sees out_ready through logic
      in_ready  <= (state_n != FULL);
      out_valid <= (state_n != EMPTY);
      unique case (state)
        EMPTY: if (push) out_q <= dec;
        HOLD: begin
          if (push && pop) out_q <= dec;
          else if (push) skid_q <= dec;
        end
        FULL: if (pop) out_q <= skid_q;
        default: ;
      endcase
      if (push && dec.ill && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign src1    = out_q.src1;
  assign src2    = out_q.src2;
  assign ALUType = out_q.op;
  assign rd      = out_q.rd;
  assign illegal = out_q.ill;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: random + directed bench for alu_op_decoder
// checked against a queue-based reference model.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALUType;
  logic [4:0]  rd;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
    int          op;
    int          rd;
    bit          ill;
  } exp_t;

  exp_t q[$];
  int   cnt_m = 0;
  int   op_tbl[8] = '{0, 2, 3, 8, 4, 5, 6, 7};

  alu_op_decoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .src1(src1), .src2(src2), .ALUType(ALUType), .rd(rd),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_dec(logic [31:0] w, logic [31:0] a,
                                   logic [31:0] b);
    exp_t e;
    int f3, f7, opc;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    e.s1 = a;
    e.s2 = b;
    e.rd = int'(w[11:7]);
    e.op = 8;
    if (opc == 'h33) begin
      if (f7 == 0) e.op = op_tbl[f3];
      else if (f7 == 'h20 && f3 == 0) e.op = 1;
    end
`ifdef ALU_DEC_IMM_EN
    else if (opc == 'h13) begin
      e.s2 = 32'($signed(w[31:20]));
      if ((f3 == 1 || f3 == 5) && f7 != 0) e.op = 8;
      else e.op = op_tbl[f3];
    end
`endif
    e.ill = (e.op == 8);
    return e;
  endfunction

  task automatic check_state(string tag);
    chk({tag, ".out_valid"}, out_valid, q.size() > 0);
    chk({tag, ".in_ready"}, in_ready, q.size() < 2);
    chk({tag, ".cnt"}, illegal_cnt, cnt_m);
    if (q.size() > 0) begin
      chk({tag, ".src1"}, src1, q[0].s1);
      chk({tag, ".src2"}, src2, q[0].s2);
      chk({tag, ".op"}, ALUType, q[0].op);
      chk({tag, ".rd"}, rd, q[0].rd);
      chk({tag, ".ill"}, illegal, q[0].ill);
    end
  endtask

  // called at a negedge; returns just after the next negedge
  task automatic step(string tag, bit v, logic [31:0] w,
                      logic [31:0] a, logic [31:0] b, bit ordy);
    bit   push, pop;
    exp_t e;
    in_valid  = v;
    instr     = w;
    rs1_data  = a;
    rs2_data  = b;
    out_ready = ordy;
    e    = ref_dec(w, a, b);
    push = v && q.size() < 2;
    pop  = ordy && q.size() > 0;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e);
      if (e.ill && cnt_m < 255) cnt_m++;
    end
    check_state(tag);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = int'($urandom_range(0, 9));
    if (k < 5) w[6:0] = 7'h33;
    else if (k < 8) w[6:0] = 7'h13;
    k = int'($urandom_range(0, 3));
    if (k < 2) w[31:25] = 7'h00;
    else if (k == 2) w[31:25] = 7'h20;
    return w;
  endfunction

  logic [31:0] held_s1;

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    instr = 32'h002081B3;
    rs1_data = 32'd1;
    rs2_data = 32'd2;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.op", ALUType, 0);
    chk("rst.cnt", illegal_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    step("dec.add", 1, 32'h002081B3, 3, 9, 1);
    chk("dec.add.op", ALUType, 0);
    chk("dec.add.s1", src1, 3);
    chk("dec.add.s2", src2, 9);
    chk("dec.add.rd", rd, 3);
    step("dec.sub", 1, 32'h402081B3, 3, 9, 1);
    chk("dec.sub.op", ALUType, 1);
    step("drain", 0, 0, 0, 0, 1);

    step("bp1", 1, 32'h0020C1B3, 11, 12, 0);
    held_s1 = src1;
    step("bp2", 1, 32'h0020E233, 21, 22, 0);
    chk("bp2.in_ready", in_ready, 0);
    step("bp3", 1, 32'h0020F2B3, 31, 32, 0);
    chk("bp.stable", src1, held_s1);
    step("bp.pop1", 0, 0, 0, 0, 1);
    chk("bp.ready_back", in_ready, 1);
    chk("bp.second", src1, 21);
    step("bp.pop2", 0, 0, 0, 0, 1);

    step("sltu", 1, 32'h0020B1B3, 5, 6, 1);
    chk("sltu.op", ALUType, 8);
    chk("sltu.ill", illegal, 1);
    chk("sltu.cnt", illegal_cnt, 1);

    step("imm", 1, 32'hFF908293, 32'h0A, 32'h55, 1);
`ifdef ALU_DEC_IMM_EN
    chk("imm.op", ALUType, 0);
    chk("imm.s2", src2, 32'hFFFFFFF9);
`else
    chk("imm.op", ALUType, 8);
    chk("imm.ill", illegal, 1);
`endif
    chk("imm.rd", rd, 5);

    for (int i = 0; i < 300; i++)
      step("sat", 1, 32'h0000007F | (i << 7), i, i, 1);
    chk("sat.cnt", illegal_cnt, 255);

    for (int i = 0; i < 2000; i++)
      step("rnd", $urandom_range(0, 3) != 0, rnd_instr(),
           $urandom, $urandom, $urandom_range(0, 2) != 0);

    step("mid1", 1, 32'h002081B3, 1, 2, 0);
    step("mid2", 1, 32'h402081B3, 3, 4, 0);
    chk("mid.full", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid.rst.out_valid", out_valid, 0);
    chk("mid.rst.in_ready", in_ready, 1);
    chk("mid.rst.cnt", illegal_cnt, 0);
    q.delete();
    cnt_m = 0;
    @(negedge clk);
    rst = 1'b0;
    step("post", 1, 32'h0041C333, 77, 88, 0);
    chk("post.s1", src1, 77);
    chk("post.op", ALUType, 4);
    step("post.drain", 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
